dest_ip_tbl_master: RTL and testbench



---
 rtl/dest_ip_tbl_pkg.sv | 20 ++
 rtl/dest_ip_tbl_master.sv | 156 +++++++++++++++
 tb/tb_dest_ip_tbl_master.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dest_ip_tbl_pkg.sv
// Shared definitions for the destination-IP filter table master:
// command codes, FSM state encoding and default table geometry.
package dest_ip_tbl_pkg;

    localparam logic [1:0] CMD_NOP   = 2'd0;
    localparam logic [1:0] CMD_READ  = 2'd1;
    localparam logic [1:0] CMD_WRITE = 2'd2;
    localparam logic [1:0] CMD_CLEAR = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_FIN  = 2'd3
    } tbl_state_t;

    localparam int DEF_TBL_DEPTH      = 32;
    localparam int DEF_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/dest_ip_tbl_master.sv
// Turns single register-bank commands (read, write, clear-all) into request
// pulses on the filter-table port, waits for the ack with a timeout, reports status.
module dest_ip_tbl_master
    import dest_ip_tbl_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int TBL_ADDR_WIDTH     = 5,
    parameter int TBL_DEPTH          = DEF_TBL_DEPTH,
    parameter int TIMEOUT_CYCLES     = DEF_TIMEOUT_CYCLES
)(
    input  logic                          AXI_ACLK,
    input  logic                          reset,
    input  logic                          cmd_wr,
    input  logic [1:0]                    cmd,
    input  logic [TBL_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] cmd_wr_data,
    output logic [C_S_AXI_DATA_WIDTH-1:0] rd_result,
    output logic                          busy,
    output logic                          done,
    output logic                          timeout_err,
    output logic                          busy_err,
    output logic                          tbl_rd_req,
    output logic                          tbl_wr_req,
    output logic [TBL_ADDR_WIDTH-1:0]     tbl_rd_addr,
    output logic [TBL_ADDR_WIDTH-1:0]     tbl_wr_addr,
    output logic [C_S_AXI_DATA_WIDTH-1:0] tbl_wr_data,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] tbl_rd_data,
    input  logic                          tbl_rd_ack,
    input  logic                          tbl_wr_ack
);

    localparam logic [7:0]              TO_LIMIT = 8'(TIMEOUT_CYCLES);
    localparam logic [TBL_ADDR_WIDTH:0] CLR_END  = (TBL_ADDR_WIDTH+1)'(TBL_DEPTH);

    tbl_state_t                    r_state;
    logic [1:0]                    r_op;
    logic [7:0]                    r_wait_cnt;
    logic [TBL_ADDR_WIDTH:0]       r_clr_cnt;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_rd_result;
    logic                          r_busy;
    logic                          r_done;
    logic                          r_timeout_err;
    logic                          r_busy_err;
    logic                          r_rd_req;
    logic                          r_wr_req;
    logic [TBL_ADDR_WIDTH-1:0]     r_rd_addr;
    logic [TBL_ADDR_WIDTH-1:0]     r_wr_addr;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_wr_data;

    logic [7:0]                    w_wait_nxt;
    logic [TBL_ADDR_WIDTH:0]       w_clr_nxt;

    // Wait counter holds at the limit instead of wrapping.
    assign w_wait_nxt = (r_wait_cnt == TO_LIMIT) ? r_wait_cnt : r_wait_cnt + 8'd1;
    assign w_clr_nxt  = r_clr_cnt + 1'b1;

    always_ff @(posedge AXI_ACLK) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_op          <= CMD_NOP;
            r_wait_cnt    <= '0;
            r_clr_cnt     <= '0;
            r_rd_result   <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_busy_err    <= 1'b0;
            r_rd_req      <= 1'b0;
            r_wr_req      <= 1'b0;
            r_rd_addr     <= '0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
        end else begin
            r_rd_req <= 1'b0;
            r_wr_req <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Requests are launched on acceptance so they are high while in REQ.
                    if (cmd_wr && (cmd != CMD_NOP)) begin
                        r_done        <= 1'b0;
                        r_timeout_err <= 1'b0;
                        r_busy_err    <= 1'b0;
                        r_busy        <= 1'b1;
                        r_op          <= cmd;
                        r_clr_cnt     <= '0;
                        r_state       <= ST_REQ;
                        if (cmd == CMD_READ) begin
                            r_rd_req  <= 1'b1;
                            r_rd_addr <= cmd_addr;
                        end else if (cmd == CMD_WRITE) begin
                            r_wr_req  <= 1'b1;
                            r_wr_addr <= cmd_addr;
                            r_wr_data <= cmd_wr_data;
                        end else begin
                            r_wr_req  <= 1'b1;
                            r_wr_addr <= '0;
                            r_wr_data <= '0;
                        end
                    end
                end
                ST_REQ: begin
                    r_wait_cnt <= '0;
                    r_state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if ((r_op == CMD_READ) && tbl_rd_ack) begin
                        r_rd_result <= tbl_rd_data;
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_FIN;
                    end else if ((r_op != CMD_READ) && tbl_wr_ack) begin
                        if ((r_op == CMD_CLEAR) && (w_clr_nxt != CLR_END)) begin
                            r_clr_cnt <= w_clr_nxt;
                            r_wr_addr <= w_clr_nxt[TBL_ADDR_WIDTH-1:0];
                            r_wr_req  <= 1'b1;
                            r_state   <= ST_REQ;
                        end else begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_FIN;
                        end
                    end else if (w_wait_nxt >= TO_LIMIT) begin
                        r_timeout_err <= 1'b1;
                        r_done        <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= ST_FIN;
                    end else begin
                        r_wait_cnt <= w_wait_nxt;
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
            // A strobe outside IDLE is dropped and only flagged.
            if (cmd_wr && (r_state != ST_IDLE)) begin
                r_busy_err <= 1'b1;
            end
        end
    end

    assign rd_result   = r_rd_result;
    assign busy        = r_busy;
    assign done        = r_done;
    assign timeout_err = r_timeout_err;
    assign busy_err    = r_busy_err;
    assign tbl_rd_req  = r_rd_req;
    assign tbl_wr_req  = r_wr_req;
    assign tbl_rd_addr = r_rd_addr;
    assign tbl_wr_addr = r_wr_addr;
    assign tbl_wr_data = r_wr_data;

endmodule

// File: tb/tb_dest_ip_tbl_master.sv
// Directed bench for dest_ip_tbl_master with a 1-cycle-ack table responder model.
module tb_dest_ip_tbl_master;

    logic        clk;
    logic        reset;
    logic        cmd_wr;
    logic [1:0]  cmd;
    logic [4:0]  cmd_addr;
    logic [31:0] cmd_wr_data;
    logic [31:0] rd_result;
    logic        busy, done, timeout_err, busy_err;
    logic        tbl_rd_req, tbl_wr_req;
    logic [4:0]  tbl_rd_addr, tbl_wr_addr;
    logic [31:0] tbl_wr_data;
    logic [31:0] tbl_rd_data;
    logic        tbl_rd_ack, tbl_wr_ack;

    // Responder model controls
    logic        rsp_en;
    logic        fill_req;
    logic        pl_we;
    logic [4:0]  pl_addr;
    logic [31:0] pl_data;
    logic        inj_rd_ack, inj_wr_ack;
    logic        rsp_rd_ack, rsp_wr_ack;
    logic [31:0] mem [0:31];

    int          rd_cnt, wr_cnt;
    logic [4:0]  wr_log [0:255];

    int n_vec = 0;
    int n_err = 0;

    dest_ip_tbl_master dut (
        .AXI_ACLK    (clk),
        .reset       (reset),
        .cmd_wr      (cmd_wr),
        .cmd         (cmd),
        .cmd_addr    (cmd_addr),
        .cmd_wr_data (cmd_wr_data),
        .rd_result   (rd_result),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .busy_err    (busy_err),
        .tbl_rd_req  (tbl_rd_req),
        .tbl_wr_req  (tbl_wr_req),
        .tbl_rd_addr (tbl_rd_addr),
        .tbl_wr_addr (tbl_wr_addr),
        .tbl_wr_data (tbl_wr_data),
        .tbl_rd_data (tbl_rd_data),
        .tbl_rd_ack  (tbl_rd_ack),
        .tbl_wr_ack  (tbl_wr_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign tbl_rd_ack = rsp_rd_ack | inj_rd_ack;
    assign tbl_wr_ack = rsp_wr_ack | inj_wr_ack;

    // Table responder: acks one cycle after each request.
    always @(posedge clk) begin
        rsp_rd_ack <= 1'b0;
        rsp_wr_ack <= 1'b0;
        if (fill_req) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'hA5000000 | 32'(i);
        end else begin
            if (rsp_en && tbl_rd_req) begin
                rsp_rd_ack  <= 1'b1;
                tbl_rd_data <= mem[tbl_rd_addr];
            end
            if (rsp_en && tbl_wr_req) begin
                rsp_wr_ack         <= 1'b1;
                mem[tbl_wr_addr]   <= tbl_wr_data;
            end
            if (pl_we) mem[pl_addr] <= pl_data;
        end
    end

    always @(posedge clk) begin
        if (tbl_rd_req) rd_cnt <= rd_cnt + 1;
        if (tbl_wr_req) begin
            wr_log[wr_cnt[7:0]] <= tbl_wr_addr;
            wr_cnt <= wr_cnt + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [1:0] c, input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        cmd_wr = 1'b1; cmd = c; cmd_addr = a; cmd_wr_data = d;
        @(negedge clk);
        cmd_wr = 1'b0; cmd = 2'd0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({busy, done, timeout_err, busy_err, tbl_rd_req, tbl_wr_req} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 000000",
                     {busy, done, timeout_err, busy_err, tbl_rd_req, tbl_wr_req});
        end
        n_vec++;
        if ({rd_result, tbl_wr_data, tbl_rd_addr, tbl_wr_addr} !== 74'd0) begin
            n_err++;
            $display("FAIL reset_data: rd_result=%h wr_data=%h rd_addr=%0d wr_addr=%0d want all 0",
                     rd_result, tbl_wr_data, tbl_rd_addr, tbl_wr_addr);
        end
    endtask

    task automatic test_nop;
        issue(2'd0, 5'd3, 32'h1234);
        n_vec++;
        if ({busy, done, tbl_rd_req, tbl_wr_req} !== 4'b0) begin
            n_err++;
            $display("FAIL nop_ignored: busy/done/rdreq/wrreq=%b want 0000",
                     {busy, done, tbl_rd_req, tbl_wr_req});
        end
    endtask

    task automatic test_read;
        int rd0;
        @(negedge clk);
        pl_we = 1'b1; pl_addr = 5'd7; pl_data = 32'h0A000001;
        @(negedge clk);
        pl_we = 1'b0;
        rd0 = rd_cnt;
        issue(2'd1, 5'd7, 32'h0);
        // cycle N+1
        n_vec++;
        if (tbl_rd_req !== 1'b1 || tbl_rd_addr !== 5'd7 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL read_req: rd_req=%b addr=%0d busy=%b want 1/7/1", tbl_rd_req, tbl_rd_addr, busy);
        end
        @(negedge clk); // N+2
        n_vec++;
        if (tbl_rd_req !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL read_pulse_width: rd_req=%b done=%b at N+2 want 0/0", tbl_rd_req, done);
        end
        @(negedge clk); // N+3
        n_vec++;
        if (rd_result !== 32'h0A000001 || done !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL read_done: rd_result=%h done=%b busy=%b want 0a000001/1/0", rd_result, done, busy);
        end
        n_vec++;
        if (rd_cnt - rd0 !== 1) begin
            n_err++;
            $display("FAIL read_req_count: got %0d want 1", rd_cnt - rd0);
        end
    endtask

    task automatic test_write;
        issue(2'd2, 5'd31, 32'hC0A80101);
        n_vec++;
        if (tbl_wr_req !== 1'b1 || tbl_wr_addr !== 5'd31 || tbl_wr_data !== 32'hC0A80101) begin
            n_err++;
            $display("FAIL write_req: wr_req=%b addr=%0d data=%h want 1/31/c0a80101",
                     tbl_wr_req, tbl_wr_addr, tbl_wr_data);
        end
        @(negedge clk);
        n_vec++;
        if (tbl_wr_req !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL write_pulse_width: wr_req=%b done=%b at N+2 want 0/0", tbl_wr_req, done);
        end
        @(negedge clk);
        n_vec++;
        if (done !== 1'b1 || busy !== 1'b0 || timeout_err !== 1'b0) begin
            n_err++;
            $display("FAIL write_done: done=%b busy=%b tmo=%b want 1/0/0", done, busy, timeout_err);
        end
        issue(2'd1, 5'd31, 32'h0);
        repeat (2) @(negedge clk);
        n_vec++;
        if (rd_result !== 32'hC0A80101 || done !== 1'b1) begin
            n_err++;
            $display("FAIL write_readback: rd_result=%h done=%b want c0a80101/1", rd_result, done);
        end
    endtask

    task automatic test_timeout;
        int rd0;
        rsp_en = 1'b0;
        rd0 = rd_cnt;
        issue(2'd1, 5'd4, 32'h0);
        repeat (16) @(negedge clk); // N+17
        n_vec++;
        if (done !== 1'b0 || timeout_err !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_early: done=%b tmo=%b busy=%b at N+17 want 0/0/1", done, timeout_err, busy);
        end
        @(negedge clk); // N+18
        n_vec++;
        if (done !== 1'b1 || timeout_err !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_flag: done=%b tmo=%b busy=%b at N+18 want 1/1/0", done, timeout_err, busy);
        end
        n_vec++;
        if (rd_result !== 32'hC0A80101) begin
            n_err++;
            $display("FAIL timeout_rd_result: got %h want c0a80101", rd_result);
        end
        repeat (4) @(negedge clk);
        n_vec++;
        if (rd_cnt - rd0 !== 1) begin
            n_err++;
            $display("FAIL timeout_single_req: got %0d requests want 1", rd_cnt - rd0);
        end
        rsp_en = 1'b1;
    endtask

    task automatic test_wrong_ack;
        rsp_en = 1'b0;
        issue(2'd2, 5'd9, 32'h11223344); // N+1
        inj_rd_ack = 1'b1;
        @(negedge clk); // N+2
        inj_rd_ack = 1'b0;
        @(negedge clk); // N+3
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL wrong_ack_ignored: done=%b busy=%b want 0/1", done, busy);
        end
        inj_wr_ack = 1'b1;
        @(negedge clk); // N+4
        inj_wr_ack = 1'b0;
        @(negedge clk); // N+5
        n_vec++;
        if (done !== 1'b1 || busy !== 1'b0 || timeout_err !== 1'b0) begin
            n_err++;
            $display("FAIL wrong_ack_then_wr_ack: done=%b busy=%b tmo=%b want 1/0/0", done, busy, timeout_err);
        end
        rsp_en = 1'b1;
    endtask

    task automatic test_busy_collision;
        int w0;
        int bad;
        w0 = wr_cnt;
        issue(2'd3, 5'd0, 32'h0); // N+1
        repeat (9) @(negedge clk); // N+10
        cmd_wr = 1'b1; cmd = 2'd2; cmd_addr = 5'd5; cmd_wr_data = 32'h55555555;
        @(negedge clk); // N+11
        cmd_wr = 1'b0; cmd = 2'd0;
        n_vec++;
        if (busy_err !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL collision_flag: busy_err=%b busy=%b want 1/1", busy_err, busy);
        end
        repeat (53) @(negedge clk); // N+64
        n_vec++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL clear_early_done: done=%b at N+64 want 0", done);
        end
        @(negedge clk); // N+65
        n_vec++;
        if (done !== 1'b1 || busy !== 1'b0 || busy_err !== 1'b1) begin
            n_err++;
            $display("FAIL clear_done: done=%b busy=%b busy_err=%b at N+65 want 1/0/1", done, busy, busy_err);
        end
        n_vec++;
        if (wr_cnt - w0 !== 32) begin
            n_err++;
            $display("FAIL clear_req_count: got %0d want 32", wr_cnt - w0);
        end
        bad = 0;
        for (int k = 0; k < 32; k++) begin
            if (wr_log[8'(w0 + k)] !== 5'(k)) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL clear_order: %0d out-of-order addresses want 0", bad);
        end
        bad = 0;
        for (int k = 0; k < 32; k++) begin
            if (mem[k] !== 32'h0) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL clear_contents: %0d nonzero entries want 0", bad);
        end
    endtask

    task automatic test_reset_mid_clear;
        int w0;
        int bad;
        @(negedge clk);
        fill_req = 1'b1;
        @(negedge clk);
        fill_req = 1'b0;
        issue(2'd3, 5'd0, 32'h0); // N+1
        repeat (23) @(negedge clk); // N+24: ack for entry 11 pending
        reset = 1'b1;
        @(negedge clk); // N+25
        reset = 1'b0;
        n_vec++;
        if ({busy, done, tbl_wr_req, tbl_rd_req, timeout_err, busy_err} !== 6'b0 ||
            tbl_wr_addr !== 5'd0 || rd_result !== 32'h0) begin
            n_err++;
            $display("FAIL reset_mid_clear_outputs: busy=%b done=%b wrreq=%b wr_addr=%0d rd_result=%h want all 0",
                     busy, done, tbl_wr_req, tbl_wr_addr, rd_result);
        end
        w0 = wr_cnt;
        repeat (6) @(negedge clk);
        n_vec++;
        if (wr_cnt != w0) begin
            n_err++;
            $display("FAIL reset_mid_clear_no_req: got %0d requests want 0", wr_cnt - w0);
        end
        bad = 0;
        for (int k = 0; k < 12; k++) if (mem[k] !== 32'h0) bad++;
        for (int k = 12; k < 32; k++) if (mem[k] !== (32'hA5000000 | 32'(k))) bad++;
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL reset_mid_clear_contents: %0d wrong entries want 0", bad);
        end
    endtask

    initial begin
        reset = 1'b1; cmd_wr = 1'b0; cmd = 2'd0; cmd_addr = 5'd0; cmd_wr_data = 32'h0;
        rsp_en = 1'b1; fill_req = 1'b1; pl_we = 1'b0; pl_addr = 5'd0; pl_data = 32'h0;
        inj_rd_ack = 1'b0; inj_wr_ack = 1'b0;
        rd_cnt = 0; wr_cnt = 0;
        @(negedge clk);
        fill_req = 1'b0;
        test_reset();
        test_nop();
        test_read();
        test_write();
        test_timeout();
        test_wrong_ack();
        test_busy_collision();
        test_reset_mid_clear();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
